data_mem_arbiter: RTL and testbench

- Two-port arbiter/sequencer in front of the single-port 16-bit-word data memory (256 words, word index = byte address bits [8:1], synchronous write, combinational read gated by MemRead).
- Port 0 is the CPU MEM stage. Port 1 is the DMA/debug loader.
- Grants one requester at a time, drives the memory's MemWrite/MemRead/address/WriteData, captures read data, and returns a one-cycle ack per completed access.
- Rejects misaligned or out-of-range addresses without touching memory.

---
 rtl/data_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_mem_arbiter: two-port arbiter/sequencer for the 16-bit data memory  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module data_mem_arbiter #(
  parameter int PRIO_MODE  = 0,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [15:0] p0_addr,
  input  logic [15:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [15:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [15:0] p1_addr,
  input  logic [15:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [15:0] p1_rdata,
  output logic        mem_write,
  output logic        mem_read,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic        bad_q, bad_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rd0_q, rd0_d;
  logic [15:0] rd1_q, rd1_d;
  logic        win;
  logic [15:0] sel_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      bad_q   <= 1'b0;
      addr_q  <= 16'h0;
      wdata_q <= 16'h0;
      rd0_q   <= 16'h0;
      rd1_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      bad_q   <= bad_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    we_d     = we_q;
    bad_d    = bad_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    win      = 1'b0;
    sel_addr = p0_addr;
    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          // On a tie, round-robin favours whichever port was not granted last.
          if (p0_req && p1_req) win = (PRIO_MODE == 1) ? 1'b0 : ~last_q;
          else                  win = p1_req;
          sel_addr = win ? p1_addr : p0_addr;
          gnt_d    = win;
          last_d   = win;
          we_d     = win ? p1_we : p0_we;
          addr_d   = sel_addr;
          wdata_d  = win ? p1_wdata : p0_wdata;
          bad_d    = sel_addr[0] | ((sel_addr >> (DEPTH_LOG2 + 1)) != 16'h0);
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          if (gnt_q) rd1_d = bad_q ? 16'h0 : mem_rdata;
          else       rd0_d = bad_q ? 16'h0 : mem_rdata;
        end
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_write = (state_q == ACCESS) & we_q & ~bad_q & ~reset;
  assign mem_read  = (state_q == ACCESS) & ~we_q & ~bad_q & ~reset;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign p0_ack    = (state_q == RESP) & ~gnt_q & ~reset;
  assign p1_ack    = (state_q == RESP) & gnt_q & ~reset;
  assign p0_err    = p0_ack & bad_q;
  assign p1_err    = p1_ack & bad_q;
  assign p0_rdata  = rd0_q;
  assign p1_rdata  = rd1_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_data_mem_arbiter: directed self-checking bench for data_mem_arbiter   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_data_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_init = 1'b1;
  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [15:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic        p0_ack, p0_err, p1_ack, p1_err, mem_write, mem_read, busy;
  logic [15:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] mem [0:255];

  logic        f_p0_req = 0, f_p1_req = 0;
  logic [15:0] f_mem_rdata = 16'h0;
  logic        f_p0_ack, f_p0_err, f_p1_ack, f_p1_err, f_mem_write, f_mem_read, f_busy;
  logic [15:0] f_p0_rdata, f_p1_rdata, f_mem_addr, f_mem_wdata;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.PRIO_MODE(0), .DEPTH_LOG2(8)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  data_mem_arbiter #(.PRIO_MODE(1), .DEPTH_LOG2(8)) dut_fp (
    .clk(clk), .reset(reset),
    .p0_req(f_p0_req), .p0_we(1'b0), .p0_addr(16'h0000), .p0_wdata(16'h0000),
    .p0_ack(f_p0_ack), .p0_err(f_p0_err), .p0_rdata(f_p0_rdata),
    .p1_req(f_p1_req), .p1_we(1'b0), .p1_addr(16'h0002), .p1_wdata(16'h0000),
    .p1_ack(f_p1_ack), .p1_err(f_p1_err), .p1_rdata(f_p1_rdata),
    .mem_write(f_mem_write), .mem_read(f_mem_read), .mem_addr(f_mem_addr),
    .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata), .busy(f_busy)
  );

  // Memory model: word k starts as 0xC000|k.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hC000 | 16'(i);
    end else if (mem_write) begin
      mem[mem_addr[8:1]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem_read ? mem[mem_addr[8:1]] : 16'h0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    p0_req = 0; p1_req = 0; f_p0_req = 0; f_p1_req = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);
  endtask

  // Issues one access from the IDLE cycle; returns at the IDLE cycle after the ack.
  task automatic access(input bit port, input logic we, input logic [15:0] addr,
                        input logic [15:0] wd, output int lat, output logic err,
                        output logic [15:0] rd, output int nwr, output int nrd,
                        output logic [15:0] saddr);
    if (port) begin p1_req = 1; p1_we = we; p1_addr = addr; p1_wdata = wd; end
    else      begin p0_req = 1; p0_we = we; p0_addr = addr; p0_wdata = wd; end
    lat = -1; err = 0; rd = 0; nwr = 0; nrd = 0; saddr = 0;
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      @(negedge clk);
      if (mem_write || mem_read) saddr = mem_addr;
      if (mem_write) nwr++;
      if (mem_read) nrd++;
      if (port ? p1_ack : p0_ack) begin
        lat = c;
        err = port ? p1_err : p0_err;
        rd  = port ? p1_rdata : p0_rdata;
      end
    end
    if (port) p1_req = 0; else p0_req = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if ({p0_ack, p1_ack, p0_err, p1_err} !== 4'b0)
      $display("FAIL reset_ack_err got %b want 0000", {p0_ack, p1_ack, p0_err, p1_err}); else n_pass++;
    n_total++; if ({p0_rdata, p1_rdata} !== 32'h0)
      $display("FAIL reset_rdata got %h want 0", {p0_rdata, p1_rdata}); else n_pass++;
    n_total++; if ({mem_write, mem_read} !== 2'b00)
      $display("FAIL reset_strobes got %b want 00", {mem_write, mem_read}); else n_pass++;
  endtask

  task automatic test_write_read();
    int lat, nwr, nrd; logic err; logic [15:0] rd, sa;
    access(0, 1, 16'h0010, 16'hBEEF, lat, err, rd, nwr, nrd, sa);
    n_total++; if (lat !== 2) $display("FAIL wr_latency got %0d want 2", lat); else n_pass++;
    n_total++; if (nwr !== 1 || sa !== 16'h0010)
      $display("FAIL wr_strobe got n=%0d addr=%h want n=1 addr=0010", nwr, sa); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL wr_err got %b want 0", err); else n_pass++;
    n_total++; if (mem[8] !== 16'hBEEF) $display("FAIL wr_mem got %h want beef", mem[8]); else n_pass++;
    access(0, 0, 16'h0010, 16'h0, lat, err, rd, nwr, nrd, sa);
    n_total++; if (lat !== 2 || rd !== 16'hBEEF || err !== 1'b0)
      $display("FAIL rd_beef got lat=%0d rd=%h err=%b want 2 beef 0", lat, rd, err); else n_pass++;
    n_total++; if (nrd !== 1 || nwr !== 0)
      $display("FAIL rd_strobes got rd=%0d wr=%0d want 1 0", nrd, nwr); else n_pass++;
  endtask

  task automatic test_bad_addr();
    int lat, nwr, nrd; logic err; logic [15:0] rd, sa;
    access(1, 1, 16'h0011, 16'hDEAD, lat, err, rd, nwr, nrd, sa);
    n_total++; if (lat !== 2 || err !== 1'b1 || nwr !== 0)
      $display("FAIL misalign_wr got lat=%0d err=%b nwr=%0d want 2 1 0", lat, err, nwr); else n_pass++;
    access(1, 1, 16'h0200, 16'hDEAD, lat, err, rd, nwr, nrd, sa);
    n_total++; if (lat !== 2 || err !== 1'b1 || nwr !== 0)
      $display("FAIL range_wr got lat=%0d err=%b nwr=%0d want 2 1 0", lat, err, nwr); else n_pass++;
    access(1, 0, 16'h0010, 16'h0, lat, err, rd, nwr, nrd, sa);
    n_total++; if (rd !== 16'hBEEF || err !== 1'b0)
      $display("FAIL bad_readback10 got rd=%h err=%b want beef 0", rd, err); else n_pass++;
    access(1, 0, 16'h0000, 16'h0, lat, err, rd, nwr, nrd, sa);
    n_total++; if (rd !== 16'hC000 || err !== 1'b0)
      $display("FAIL bad_readback0 got rd=%h err=%b want c000 0", rd, err); else n_pass++;
    access(1, 0, 16'h0011, 16'h0, lat, err, rd, nwr, nrd, sa);
    n_total++; if (rd !== 16'h0 || err !== 1'b1 || nrd !== 0)
      $display("FAIL misalign_rd got rd=%h err=%b nrd=%0d want 0 1 0", rd, err, nrd); else n_pass++;
  endtask

  task automatic test_last_word();
    int lat, nwr, nrd; logic err; logic [15:0] rd, sa;
    access(0, 1, 16'h01FE, 16'h1234, lat, err, rd, nwr, nrd, sa);
    n_total++; if (err !== 1'b0 || nwr !== 1 || sa !== 16'h01FE)
      $display("FAIL last_wr got err=%b nwr=%0d addr=%h want 0 1 01fe", err, nwr, sa); else n_pass++;
    access(0, 0, 16'h01FE, 16'h0, lat, err, rd, nwr, nrd, sa);
    n_total++; if (rd !== 16'h1234 || err !== 1'b0)
      $display("FAIL last_rd got rd=%h err=%b want 1234 0", rd, err); else n_pass++;
    access(0, 0, 16'h0000, 16'h0, lat, err, rd, nwr, nrd, sa);
    n_total++; if (rd !== 16'hC000) $display("FAIL no_wrap got %h want c000", rd); else n_pass++;
  endtask

  task automatic test_round_robin();
    int cyc[4]; bit prt[4]; int n = 0; bit both = 0;
    do_reset();
    p0_we = 0; p0_addr = 16'h0010; p1_we = 0; p1_addr = 16'h01FE;
    p0_req = 1; p1_req = 1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (p0_ack && p1_ack) both = 1;
      if ((p0_ack || p1_ack) && n < 4) begin cyc[n] = c; prt[n] = p1_ack; n++; end
    end
    p0_req = 0; p1_req = 0;
    n_total++; if (n !== 4 || both) $display("FAIL rr_count got %0d both=%b want 4 0", n, both); else n_pass++;
    n_total++; if (cyc[0] !== 2 || cyc[1] !== 5 || cyc[2] !== 8 || cyc[3] !== 11)
      $display("FAIL rr_timing got %0d %0d %0d %0d want 2 5 8 11", cyc[0], cyc[1], cyc[2], cyc[3]); else n_pass++;
    n_total++; if ({prt[0], prt[1], prt[2], prt[3]} !== 4'b0101)
      $display("FAIL rr_order got %b want 0101", {prt[0], prt[1], prt[2], prt[3]}); else n_pass++;
    n_total++; if (p0_rdata !== 16'hBEEF || p1_rdata !== 16'h1234)
      $display("FAIL rr_rdata got %h %h want beef 1234", p0_rdata, p1_rdata); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_fixed_priority();
    int a0 = 0, a1 = 0, rel = -1;
    f_p0_req = 1; f_p1_req = 1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (f_p0_ack) a0++;
      if (f_p1_ack) a1++;
    end
    f_p0_req = 0;
    n_total++; if (a0 !== 4 || a1 !== 0)
      $display("FAIL fp_starve got p0=%0d p1=%0d want 4 0", a0, a1); else n_pass++;
    for (int c = 1; c <= 6 && rel < 0; c++) begin
      @(negedge clk);
      if (f_p1_ack) rel = c;
    end
    f_p1_req = 0;
    n_total++; if (rel !== 2) $display("FAIL fp_release got %0d want 2", rel); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    int lat, nwr, nrd, acks = 0; logic err; logic [15:0] rd, sa;
    p0_req = 1; p0_we = 1; p0_addr = 16'h0004; p0_wdata = 16'hAAAA;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_total++; if (mem_write !== 1'b0 || busy !== 1'b1)
      $display("FAIL rst_access got wr=%b busy=%b want 0 1", mem_write, busy); else n_pass++;
    p0_req = 0;
    @(negedge clk);
    reset = 1'b0;
    n_total++; if (busy !== 1'b0 || p0_ack !== 1'b0 || p0_rdata !== 16'h0)
      $display("FAIL rst_idle got busy=%b ack=%b rd=%h want 0 0 0", busy, p0_ack, p0_rdata); else n_pass++;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (p0_ack) acks++;
    end
    n_total++; if (acks !== 0) $display("FAIL rst_no_ack got %0d want 0", acks); else n_pass++;
    access(0, 0, 16'h0004, 16'h0, lat, err, rd, nwr, nrd, sa);
    n_total++; if (rd !== 16'hC002 || lat !== 2)
      $display("FAIL rst_prior got rd=%h lat=%0d want c002 2", rd, lat); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int cyc[2]; int n = 0, nrd = 0;
    p0_req = 1; p0_we = 0; p0_addr = 16'h0010;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_read) nrd++;
      if (p0_ack) begin if (n < 2) cyc[n] = c; n++; end
      if (c == 4) p0_req = 0;
    end
    n_total++; if (n !== 2 || nrd !== 2)
      $display("FAIL b2b_count got acks=%0d reads=%0d want 2 2", n, nrd); else n_pass++;
    n_total++; if (cyc[0] !== 2 || cyc[1] !== 5)
      $display("FAIL b2b_timing got %0d %0d want 2 5", cyc[0], cyc[1]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bad_addr();
    test_last_word();
    test_round_robin();
    test_fixed_priority();
    test_reset_mid_access();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
